mips_avalon_master: RTL and testbench
=====================================

MIPS_AVALON_MASTER -- requirements
Module: mips_avalon_master

Interface
REQ-001 The block SHALL have parameter WAIT_TIMEOUT, default 64, giving the maximum number of consecutive waitrequest-high cycles before the access is aborted; 0 disables the timeout.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: CPU load/store request present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-008 The block SHALL have port req_signed, input, 1 bit: sign-extend load result.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-justified.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port resp_err, output, 1 bit: completion was misaligned, illegal or timed out.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: extended load data.
REQ-014 The block SHALL have ports address (output, 32), read (output, 1), write (output, 1), writedata (output, 32), byteenable (output, 4), waitrequest (input, 1), readdata (input, 32), forming the Avalon-MM master port.

Function
REQ-015 The block SHALL implement states IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, req_valid=1 SHALL accept the request at that edge and latch all req_* fields.
REQ-017 A request that is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or uses req_size=11 SHALL go directly to RESP with resp_err=1, resp_rdata=0 and no bus cycle.
REQ-018 A legal request SHALL enter BUS, driving registered outputs from the next cycle: address={req_addr[31:2],2'b00}, read=!req_write, write=req_write.
REQ-019 byteenable SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011 or 4'b1100 (by addr[1]) for half, and 4'b1111 for word.
REQ-020 writedata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-021 In BUS, address, read, write, writedata and byteenable SHALL be held stable while waitrequest=1.
REQ-022 At the first edge in BUS with waitrequest=0, the block SHALL capture readdata for loads, deassert read/write, and enter RESP.
REQ-023 The load result SHALL be the selected byte or halfword lane, sign-extended if req_signed=1 and zero-extended otherwise; the word is passed unchanged.
REQ-024 A counter SHALL count BUS cycles with waitrequest=1; when it reaches WAIT_TIMEOUT (if nonzero), read/write SHALL deassert and RESP SHALL be entered with resp_err=1.
REQ-025 In RESP, resp_valid SHALL be 1 for exactly one cycle, with resp_err/resp_rdata valid; for a store, resp_rdata=0. The next state SHALL be IDLE.
REQ-026 Minimum latency from acceptance edge to resp_valid SHALL be 2 cycles (waitrequest low in first BUS cycle).
REQ-027 read and write SHALL never both be 1; outputs other than read/write SHALL be don't-care-free, holding last values in IDLE.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state IDLE, read=0, write=0, resp_valid=0, resp_err=0, resp_rdata=0, address=0, writedata=0, byteenable=0, and the timeout counter to 0.
REQ-029 Reset asserted mid-BUS SHALL drop read/write immediately and produce no resp_valid for the aborted access.

Verification
REQ-030 Word store to 0x10 with data 0xDEADBEEF, slave delay 2 -> write=1, byteenable=1111, address=0x10 held for the full waitrequest window; one resp_valid with err=0.
REQ-031 Byte store 0xAB to 0x12, then signed byte load from 0x12 -> byteenable=0100, writedata=0xABABABAB; load resp_rdata=0xFFFFFFAB; unsigned load returns 0x000000AB.
REQ-032 Signed half load from 0x16 with memory word 0x80017FFF -> byteenable=1100, resp_rdata=0xFFFF8001.
REQ-033 Word load from 0x11 -> no read/write pulse; resp_valid 1 cycle after acceptance with resp_err=1.
REQ-034 With WAIT_TIMEOUT=4 and waitrequest tied high -> read drops after 4 wait cycles; resp_err=1.
REQ-035 reset_n pulsed low during BUS -> read=0 in the same cycle; no resp_valid; next request completes normally.

Source files
------------

// File: rtl/mips_avalon_master.sv
// CPU load/store port to Avalon-MM master bridge.
// Handles lane steering, load extension, alignment checks and a waitrequest timeout.
module mips_avalon_master #(
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        req_write_q, req_write_d;
    logic [1:0]  req_size_q, req_size_d;
    logic        req_signed_q, req_signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [31:0] load_result;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        timeout_hit;

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Stores are replicated across every lane so the slave can pick any enabled byte.
    always_comb begin
        be_new = 4'b1111;
        wd_new = req_wdata;
        unique case (req_size)
            2'b00: begin
                be_new = 4'b0001 << req_addr[1:0];
                wd_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_new = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_new = {2{req_wdata[15:0]}};
            end
            default: begin
                be_new = 4'b1111;
                wd_new = req_wdata;
            end
        endcase
    end

    always_comb begin
        load_byte = readdata[7:0];
        unique case (lane_q)
            2'd0:    load_byte = readdata[7:0];
            2'd1:    load_byte = readdata[15:8];
            2'd2:    load_byte = readdata[23:16];
            default: load_byte = readdata[31:24];
        endcase
        load_half = lane_q[1] ? readdata[31:16] : readdata[15:0];
        unique case (req_size_q)
            2'b00:   load_result = {{24{req_signed_q & load_byte[7]}}, load_byte};
            2'b01:   load_result = {{16{req_signed_q & load_half[15]}}, load_half};
            default: load_result = readdata;
        endcase
    end

    assign timeout_hit = (WAIT_TIMEOUT != 0) && ((wait_cnt_q + 32'd1) == 32'(WAIT_TIMEOUT));

    always_comb begin
        state_d      = state_q;
        req_write_d  = req_write_q;
        req_size_d   = req_size_q;
        req_signed_d = req_signed_q;
        lane_d       = lane_q;
        wait_cnt_d   = wait_cnt_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_write_d  = req_write;
                    req_size_d   = req_size;
                    req_signed_d = req_signed;
                    lane_d       = req_addr[1:0];
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d      = BUS;
                        address_d    = {req_addr[31:2], 2'b00};
                        read_d       = ~req_write;
                        write_d      = req_write;
                        byteenable_d = be_new;
                        writedata_d  = wd_new;
                        wait_cnt_d   = 32'd0;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    state_d      = RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = req_write_q ? 32'd0 : load_result;
                end else if (timeout_hit) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    state_d      = RESP;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_write_q  <= 1'b0;
            req_size_q   <= 2'b00;
            req_signed_q <= 1'b0;
            lane_q       <= 2'b00;
            wait_cnt_q   <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_write_q  <= req_write_d;
            req_size_q   <= req_size_d;
            req_signed_q <= req_signed_d;
            lane_q       <= lane_d;
            wait_cnt_q   <= wait_cnt_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_avalon_master.sv
// Randomized bench for mips_avalon_master against a byte-addressed memory model
// and a simple Avalon slave with programmable wait states.
module tb_mips_avalon_master;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_avalon_master #(.WAIT_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .waitrequest(waitrequest),
        .readdata   (readdata)
    );

    // Reference memory, byte granular; the slave keeps its own word copy.
    logic [7:0]  rmem [0:255];
    logic [31:0] smem [0:63];
    logic        init_mem = 1'b0;
    int unsigned s_cnt = 0;
    int unsigned s_delay = 0;

    assign waitrequest = (s_cnt < s_delay);
    assign readdata    = smem[address[7:2]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++)
                smem[i] <= {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
        end else if (read || write) begin
            if (waitrequest) s_cnt <= s_cnt + 1;
            else begin
                s_cnt <= 0;
                if (write) smem[address[7:2]] <= merge(smem[address[7:2]], writedata, byteenable);
            end
        end else begin
            s_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int unsigned dly);
        logic        bad, tmo, seen;
        int unsigned nb;
        int          lat, busy, exp_lat, exp_busy;
        logic [31:0] exp_rd, exp_be, exp_wd, exp_addr, mask;
        logic [7:0]  ix;

        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        tmo = !bad && (dly >= TO);
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_be   = ((32'd1 << nb) - 32'd1) << a[1:0];
        exp_wd   = (sz == 2'b00) ? {24'd0, wd[7:0]} * 32'h0101_0101 :
                   (sz == 2'b01) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
        exp_rd   = 32'd0;
        if (!bad && !tmo && !w) begin
            for (int i = 0; i < int'(nb); i++) begin
                ix = a[7:0] + 8'(i);
                exp_rd = exp_rd | ({24'd0, rmem[ix]} << (8 * i));
            end
            if (sg && nb < 4 && exp_rd[8*nb-1]) begin
                mask   = (32'd1 << (8 * nb)) - 32'd1;
                exp_rd = exp_rd | ~mask;
            end
        end
        exp_lat  = bad ? 1 : tmo ? int'(TO) + 1 : int'(dly) + 2;
        exp_busy = bad ? 0 : tmo ? int'(TO) : int'(dly) + 1;

        @(negedge clk);
        s_delay = dly;
        check("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat  = 1;
        busy = 0;
        seen = 1'b0;
        while (lat <= 20) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            if (read || write) begin
                busy++;
                check("bus_rw", {30'd0, read, write}, {30'd0, ~w, w});
                check("bus_addr", address, exp_addr);
                check("bus_be", {28'd0, byteenable}, exp_be);
                if (w) check("bus_wdata", writedata, exp_wd);
            end
            @(negedge clk);
            lat++;
        end
        check("resp_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("latency", lat, exp_lat);
            check("bus_cycles", busy, exp_busy);
            check("resp_err", {31'd0, resp_err}, {31'd0, bad | tmo});
            check("resp_rdata", resp_rdata, exp_rd);
            check("rw_idle", {30'd0, read, write}, 32'd0);
            @(negedge clk);
            check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        end
        if (w && !bad && !tmo) begin
            for (int i = 0; i < int'(nb); i++) begin
                ix = a[7:0] + 8'(i);
                rmem[ix] = wd[8*i +: 8];
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
        init_mem = 1'b1;
        repeat (2) @(negedge clk);
        init_mem = 1'b0;
        check("rst_rw", {30'd0, read, write}, 32'd0);
        check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_addr", address, 32'd0);
        check("rst_wdata", writedata, 32'd0);
        check("rst_be", {28'd0, byteenable}, 32'd0);
        reset_n = 1'b1;

        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2);
        run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AB, 0);
        run_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1);
        run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 0);
        run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h8001_7FFF, 0);
        run_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1);
        run_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 3);
        run_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0);
        run_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 100);
        run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h1234, TO);
        run_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, TO - 1);

        // Reset during a stalled read must drop the strobe at once and lose the response.
        @(negedge clk);
        s_delay    = 1000;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_addr   = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_read", {31'd0, read}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rw", {30'd0, read, write}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1);

        for (int k = 0; k < 60; k++) begin
            run_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                    $urandom, $urandom_range(0, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
